rf_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources: port A (single-cycle ALU writeback) and port B (long-latency unit: multiply/divide or load return). It grants at most one write per cycle, drives the register file's WEN/RW/busW from registers, and bounds B's starvation. It also keeps a pending-write scoreboard that issue logic uses to stall reads of registers whose long-latency result has not yet landed.

---
 rtl/rf_pkg.sv | 24 ++
 rtl/rf_scoreboard.sv | 43 ++++
 rtl/rf_write_arbiter.sv | 109 ++++++++++
 tb/tb_rf_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the writeback arbiter and
// its pending-write scoreboard.
package rf_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;
  localparam int RF_STARVE_W = 4;

  localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = '0;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } rf_grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write bitmask: one bit per register still waiting on a long-latency
// result. Set on issue, cleared when the result commits; set beats clear.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_set_valid,
  input  logic [ADDR_W-1:0]   i_set_addr,
  input  logic                i_clr_valid,
  input  logic [ADDR_W-1:0]   i_clr_addr,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_busy_next;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_valid) w_set_mask[i_set_addr] = 1'b1;
    if (i_clr_valid) w_clr_mask[i_clr_addr] = 1'b1;
    // Clear first, then set, so an issue landing on the commit edge survives.
    w_busy_next    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-source arbiter for the register file write port with bounded starvation
// of the long-latency source and a registered write stage.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int STARVE_MAX = 3
) (
  input  logic                   Clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]      b_data,
  input  logic                   alloc_valid,
  input  logic [ADDR_W-1:0]      alloc_addr,
  output logic [2**ADDR_W-1:0]   busy,
  output logic                   WEN,
  output logic [ADDR_W-1:0]      RW,
  output logic [DATA_W-1:0]      busW
);

  // Handshake: a request transfers in the cycle where valid && ready are both
  // high at the rising edge; an unaccepted request must be held unchanged.

  localparam logic [RF_STARVE_W-1:0] STARVE_LIM = RF_STARVE_W'(STARVE_MAX);

  rf_grant_e              w_grant;
  logic [ADDR_W-1:0]      w_win_addr;
  logic [DATA_W-1:0]      w_win_data;
  logic                   w_commit;

  logic [RF_STARVE_W-1:0] r_starve;
  logic                   r_wen;
  logic                   r_wen_from_b;
  logic [ADDR_W-1:0]      r_rw;
  logic [DATA_W-1:0]      r_busw;

  always_comb begin
    w_grant = GNT_NONE;
    if (rst) begin
      w_grant = GNT_NONE;
    end else if (b_valid && (!a_valid || (r_starve == STARVE_LIM))) begin
      w_grant = GNT_B;
    end else if (a_valid) begin
      w_grant = GNT_A;
    end
  end

  assign a_ready = (w_grant == GNT_A);
  assign b_ready = (w_grant == GNT_B);

  always_comb begin
    w_win_addr = a_addr;
    w_win_data = a_data;
    if (w_grant == GNT_B) begin
      w_win_addr = b_addr;
      w_win_data = b_data;
    end
  end

  // Register 0 writes are accepted but never reach the register file.
  assign w_commit = (w_grant != GNT_NONE) && (w_win_addr != '0);

  always_ff @(posedge Clk) begin
    if (rst) begin
      r_starve     <= '0;
      r_wen        <= 1'b0;
      r_wen_from_b <= 1'b0;
      r_rw         <= '0;
      r_busw       <= '0;
    end else begin
      if (w_grant == GNT_B) begin
        r_starve <= '0;
      end else if (b_valid && (r_starve != STARVE_LIM)) begin
        r_starve <= r_starve + RF_STARVE_W'(1);
      end
      r_wen        <= w_commit;
      r_wen_from_b <= w_commit && (w_grant == GNT_B);
      if (w_commit) begin
        r_rw   <= w_win_addr;
        r_busw <= w_win_data;
      end
    end
  end

  assign WEN  = r_wen;
  assign RW   = r_rw;
  assign busW = r_busw;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (2 ** ADDR_W)
  ) u_scoreboard (
    .i_clk       (Clk),
    .i_rst       (rst),
    .i_set_valid (alloc_valid),
    .i_set_addr  (alloc_addr),
    .i_clr_valid (r_wen_from_b),
    .i_clr_addr  (r_rw),
    .o_busy      (busy)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: reset, starvation and scoreboard sequences, a
// vector table, then randomized traffic against a transaction-level model.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 32;
  localparam int SMAX = 3;

  logic          Clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid, b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          alloc_valid;
  logic [AW-1:0] alloc_addr;
  logic [NR-1:0] busy;
  logic          WEN;
  logic [AW-1:0] RW;
  logic [DW-1:0] busW;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW+DW-1:0] exp_q[$];

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .Clk         (Clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .busy        (busy),
    .WEN         (WEN),
    .RW          (RW),
    .busW        (busW)
  );

  // Clock and reset
  always #5 Clk = ~Clk;

  typedef struct {
    rf_wr_req_t    a;
    rf_wr_req_t    b;
    logic          lv;
    logic [AW-1:0] la;
    logic          ea;
    logic          eb;
    logic          ewen;
    logic [AW-1:0] erw;
    logic [DW-1:0] ebusw;
    logic [NR-1:0] ebusy;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic rf_wr_req_t req(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    rf_wr_req_t r;
    r.valid = v;
    r.addr  = ad;
    r.data  = d;
    return r;
  endfunction

  function automatic vec_t mk(input rf_wr_req_t a, input rf_wr_req_t b,
                              input logic lv, input logic [AW-1:0] la,
                              input logic ea, input logic eb, input logic ewen,
                              input logic [AW-1:0] erw, input logic [DW-1:0] ebusw,
                              input logic [NR-1:0] ebusy);
    vec_t v;
    v.a = a; v.b = b; v.lv = lv; v.la = la;
    v.ea = ea; v.eb = eb; v.ewen = ewen; v.erw = erw; v.ebusw = ebusw; v.ebusy = ebusy;
    return v;
  endfunction

  // Driver tasks
  task automatic drive(input rf_wr_req_t a, input rf_wr_req_t b,
                       input logic lv, input logic [AW-1:0] la);
    a_valid     = a.valid;
    a_addr      = a.addr;
    a_data      = a.data;
    b_valid     = b.valid;
    b_addr      = b.addr;
    b_data      = b.data;
    alloc_valid = lv;
    alloc_addr  = la;
  endtask

  task automatic to_after_edge();
    @(posedge Clk);
    #1;
  endtask

  // Transaction-level reference state for the random phase
  int            b_wait;
  int            b_inflight;
  logic [NR-1:0] busy_m;
  logic [AW-1:0] m_rw;
  logic [DW-1:0] m_busw;

  initial begin
    logic [NR-1:0] b9;
    logic [AW+DW-1:0] w;
    logic m_ga, m_gb, a_taken, b_taken;
    rf_wr_req_t idle;

    b9   = '0;
    b9[9] = 1'b1;
    idle = req(1'b0, '0, '0);
    rst  = 1'b1;
    drive(idle, idle, 1'b0, '0);

    vecs[0]  = mk(req(1, 5, 32'h10), idle, 1, 9, 1, 0, 1, 5, 32'h10, b9);
    vecs[1]  = mk(req(1, 6, 32'h11), idle, 0, 0, 1, 0, 1, 6, 32'h11, b9);
    vecs[2]  = mk(req(1, 7, 32'h12), idle, 0, 0, 1, 0, 1, 7, 32'h12, b9);
    vecs[3]  = mk(req(1, 8, 32'h13), idle, 0, 0, 1, 0, 1, 8, 32'h13, b9);
    vecs[4]  = mk(idle, req(1, 9, 32'hDEADBEEF), 0, 0, 0, 1, 1, 9, 32'hDEADBEEF, b9);
    vecs[5]  = mk(idle, idle, 0, 0, 0, 0, 0, 9, 32'hDEADBEEF, '0);
    vecs[6]  = mk(idle, idle, 1, 9, 0, 0, 0, 9, 32'hDEADBEEF, b9);
    vecs[7]  = mk(idle, req(1, 9, 32'hCAFEF00D), 0, 0, 0, 1, 1, 9, 32'hCAFEF00D, b9);
    vecs[8]  = mk(idle, idle, 1, 9, 0, 0, 0, 9, 32'hCAFEF00D, b9);
    vecs[9]  = mk(req(1, 0, 32'h55), idle, 1, 0, 1, 0, 0, 9, 32'hCAFEF00D, b9);
    vecs[10] = mk(req(1, 3, 32'h33), req(1, 4, 32'h44), 0, 0, 1, 0, 1, 3, 32'h33, b9);
    vecs[11] = mk(idle, req(1, 4, 32'h44), 0, 0, 0, 1, 1, 4, 32'h44, b9);

    // Reset held for two cycles with every request high
    @(negedge Clk);
    rst = 1'b1;
    drive(req(1, 1, 32'hA1), req(1, 2, 32'hB2), 1'b1, 5'd3);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_a_ready", a_ready, 0);
      check("rst_b_ready", b_ready, 0);
      to_after_edge();
      check("rst_wen", WEN, 0);
      check("rst_busy", busy, 0);
      @(negedge Clk);
    end

    // Starvation: both sources always valid, B forced through every 4th cycle
    rst         = 1'b0;
    alloc_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      check("starve_a_ready", a_ready, (c % 4) != 3);
      check("starve_b_ready", b_ready, (c % 4) == 3);
      to_after_edge();
      check("starve_wen", WEN, 1);
      check("starve_rw", RW, ((c % 4) == 3) ? 5'd2 : 5'd1);
      @(negedge Clk);
    end

    // Vector table from a fresh reset
    rst = 1'b1;
    drive(idle, idle, 1'b0, '0);
    to_after_edge();
    @(negedge Clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].lv, vecs[i].la);
      #1;
      check($sformatf("vec%0d_a_ready", i), a_ready, vecs[i].ea);
      check($sformatf("vec%0d_b_ready", i), b_ready, vecs[i].eb);
      to_after_edge();
      check($sformatf("vec%0d_wen", i), WEN, vecs[i].ewen);
      check($sformatf("vec%0d_rw", i), RW, vecs[i].erw);
      check($sformatf("vec%0d_busw", i), busW, vecs[i].ebusw);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
      @(negedge Clk);
    end

    // Reset lands while a B write is in flight
    drive(idle, idle, 1'b1, 5'd12);
    to_after_edge();
    @(negedge Clk);
    drive(idle, req(1, 12, 32'h1234), 1'b0, '0);
    #1;
    check("mid_b_ready", b_ready, 1);
    to_after_edge();
    check("mid_wen_before", WEN, 1);
    check("mid_busy12_before", busy[12], 1);
    @(negedge Clk);
    rst = 1'b1;
    drive(idle, idle, 1'b0, '0);
    to_after_edge();
    check("mid_wen_after", WEN, 0);
    check("mid_busy_after", busy, 0);
    check("mid_rw_after", RW, 0);
    @(negedge Clk);
    rst = 1'b0;

    // Randomized traffic against the reference model
    b_wait     = 0;
    b_inflight = -1;
    busy_m     = '0;
    m_rw       = '0;
    m_busw     = '0;
    a_taken    = 1'b1;
    b_taken    = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!a_valid || a_taken) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr  = AW'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      if (!b_valid || b_taken) begin
        b_valid = ($urandom_range(0, 1) != 0);
        b_addr  = AW'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      alloc_valid = ($urandom_range(0, 3) == 0);
      alloc_addr  = AW'($urandom_range(0, 7));
      rst         = ($urandom_range(0, 99) == 0);
      #1;
      m_gb = !rst && b_valid && (!a_valid || b_wait >= SMAX);
      m_ga = !rst && a_valid && !m_gb;
      check("rand_a_ready", a_ready, m_ga);
      check("rand_b_ready", b_ready, m_gb);
      a_taken = m_ga;
      b_taken = m_gb;

      if (rst) begin
        exp_q.delete();
        b_wait     = 0;
        b_inflight = -1;
        busy_m     = '0;
        m_rw       = '0;
        m_busw     = '0;
      end else begin
        if (b_inflight >= 0) busy_m[b_inflight] = 1'b0;
        b_inflight = -1;
        if (alloc_valid && alloc_addr != 0) busy_m[alloc_addr] = 1'b1;
        if (m_gb) b_wait = 0;
        else if (b_valid && b_wait < SMAX) b_wait++;
        if (m_ga && a_addr != 0) exp_q.push_back({a_addr, a_data});
        if (m_gb && b_addr != 0) begin
          exp_q.push_back({b_addr, b_data});
          b_inflight = int'(b_addr);
        end
      end

      to_after_edge();
      if (exp_q.size() > 0) begin
        w      = exp_q.pop_front();
        m_rw   = w[AW+DW-1:DW];
        m_busw = w[DW-1:0];
        check("rand_wen", WEN, 1);
      end else begin
        check("rand_wen", WEN, 0);
      end
      check("rand_rw", RW, m_rw);
      check("rand_busw", busW, m_busw);
      check("rand_busy", busy, busy_m);
      @(negedge Clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
